reorder_tag_manager: RTL and testbench
======================================

REORDER_TAG_MANAGER -- requirements
Module: reorder_tag_manager

Interface
REQ-001 Parameter TAG_WIDTH, 6, width of reorder tag buses.
REQ-002 Parameter CIRCULAR_BUFFER_SIZE, 3, number of tag slots; legal tags 0..CIRCULAR_BUFFER_SIZE-1.
REQ-003 Parameter TIMEOUT_CYCLES, 64, pending-age limit; used only with REORDER_TIMEOUT_EN.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 alloc_req  input  1  ingress requests a tag for a new packet.
REQ-007 alloc_gnt  output  1  tag granted this cycle.
REQ-008 alloc_tag  output  TAG_WIDTH  tag granted; valid when alloc_gnt=1.
REQ-009 verdict_valid  input  1  filter verdict strobe.
REQ-010 verdict_tag  input  TAG_WIDTH  tag the verdict applies to.
REQ-011 verdict_accept  input  1  1=accept, 0=reject.
REQ-012 reorder_tag_out  input  TAG_WIDTH  head tag presented by the circular buffer.
REQ-013 packet_status  output  2  status of reorder_tag_out: 00 pending, 01 rejected, 11 accepted.
REQ-014 release_valid  input  1  buffer finished forwarding/dropping the head packet.
REQ-015 release_tag  input  TAG_WIDTH  tag being released.
REQ-016 full  output  1  all slots in use.
REQ-017 empty  output  1  no slots in use.
REQ-018 in_use_count  output  TAG_WIDTH  number of slots in use.
REQ-019 err_pulse  output  1  one-cycle pulse on protocol violation.

Function
REQ-020 Each slot SHALL hold state FREE, PENDING, REJECTED or ACCEPTED.
REQ-021 Tags SHALL be allocated in strict round-robin order via alloc pointer, wrapping CIRCULAR_BUFFER_SIZE-1 -> 0.
REQ-022 alloc_gnt SHALL be combinational: alloc_req AND NOT full (full from registered state); alloc_tag = alloc pointer.
REQ-023 On grant, slot SHALL become PENDING and alloc pointer SHALL advance on the same clock edge.
REQ-024 Verdict on a PENDING slot SHALL set ACCEPTED (verdict_accept=1) or REJECTED (0), visible on packet_status the next cycle.
REQ-025 Verdict on a non-PENDING slot SHALL be ignored (first verdict wins); verdict on FREE slot or tag >= CIRCULAR_BUFFER_SIZE SHALL also pulse err_pulse.
REQ-026 packet_status SHALL be combinational lookup of reorder_tag_out; FREE or out-of-range tag SHALL read 00.
REQ-027 Releases SHALL be in order: release_tag must equal release pointer; matching release sets slot FREE and advances release pointer with wrap.
REQ-028 Release of mismatched tag, FREE slot, or PENDING slot SHALL be ignored and pulse err_pulse.
REQ-029 in_use_count SHALL update as count + grant - release in one cycle; simultaneous grant and release when full SHALL leave count at CIRCULAR_BUFFER_SIZE (grant blocked, release frees).
REQ-030 Verdict and release for same tag in same cycle: release SHALL win (slot FREE).
REQ-031 Grant and verdict for the same slot in one cycle cannot occur legally; verdict SHALL be ignored with err_pulse.
REQ-032 full = (count == CIRCULAR_BUFFER_SIZE); empty = (count == 0); both from registered state.

Reset
REQ-033 rst SHALL asynchronously force all slots FREE, both pointers 0, count 0, err_pulse 0.
REQ-034 After reset: alloc_gnt follows alloc_req, alloc_tag 0, empty 1, full 0, packet_status 00.
REQ-035 rst mid-operation SHALL discard all outstanding tags and verdicts; no state survives.

Configuration
REQ-036 Macro REORDER_TIMEOUT_EN: when defined, each slot SHALL have an age counter cleared on grant, incrementing while PENDING; on reaching TIMEOUT_CYCLES slot SHALL become REJECTED and err_pulse SHALL pulse once.
REQ-037 Without REORDER_TIMEOUT_EN, no age counters SHALL exist and PENDING slots wait indefinitely.

Verification
REQ-038 Reset, alloc_req held 4 cycles -> grants tags 0,1,2; 4th cycle alloc_gnt=0, full=1, count=3.
REQ-039 Tags 0..2 allocated; verdicts tag1 accept, tag0 reject -> reorder_tag_out=0 reads 01, =1 reads 11, =2 reads 00.
REQ-040 Full, release tag0 with alloc_req same cycle -> alloc_gnt=0, next cycle count=2, then grant of tag 0.
REQ-041 Release tag1 while release pointer=0 -> ignored, err_pulse=1 one cycle, count unchanged.
REQ-042 Second verdict reject on tag already ACCEPTED -> status stays 11, no err_pulse.
REQ-043 With REORDER_TIMEOUT_EN, TIMEOUT_CYCLES=8, tag0 pending 8 cycles -> status 01, single err_pulse; rst asserted mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/reorder_tag_manager.sv
// Reorder tag manager: round-robin tag allocation, per-slot verdict tracking and in-order release.
// Optional macro REORDER_TIMEOUT_EN adds per-slot age counters that auto-reject stale PENDING slots.

// state      | meaning
// S_FREE     | slot unused, available for allocation
// S_PENDING  | tag granted, waiting for filter verdict
// S_REJECTED | verdict reject (or timeout), waiting for release
// S_ACCEPTED | verdict accept, waiting for release
module reorder_tag_manager #(
  parameter int TAG_WIDTH            = 6,
  parameter int CIRCULAR_BUFFER_SIZE = 3,
  parameter int TIMEOUT_CYCLES       = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 alloc_req,
  output logic                 alloc_gnt,
  output logic [TAG_WIDTH-1:0] alloc_tag,
  input  logic                 verdict_valid,
  input  logic [TAG_WIDTH-1:0] verdict_tag,
  input  logic                 verdict_accept,
  input  logic [TAG_WIDTH-1:0] reorder_tag_out,
  output logic [1:0]           packet_status,
  input  logic                 release_valid,
  input  logic [TAG_WIDTH-1:0] release_tag,
  output logic                 full,
  output logic                 empty,
  output logic [TAG_WIDTH-1:0] in_use_count,
  output logic                 err_pulse
);

  localparam int N = CIRCULAR_BUFFER_SIZE;
  localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(N - 1);
  localparam logic [TAG_WIDTH-1:0] NUM_SLOTS = TAG_WIDTH'(N);

  typedef enum logic [1:0] {
    S_FREE     = 2'd0,
    S_PENDING  = 2'd1,
    S_REJECTED = 2'd2,
    S_ACCEPTED = 2'd3
  } slot_t;

  slot_t                slot_q [N];
  slot_t                slot_d [N];
  logic [TAG_WIDTH-1:0] alloc_ptr;
  logic [TAG_WIDTH-1:0] rel_ptr;
  logic [TAG_WIDTH-1:0] count;
  logic                 err_q;
  slot_t                verd_slot;
  slot_t                rel_slot;
  logic                 verd_err;
  logic                 rel_ok;
  logic                 rel_err;
  logic [N-1:0]         timeout_hit;
  logic [N-1:0]         timeout_fire;

  assign full         = (count == NUM_SLOTS);
  assign empty        = (count == '0);
  assign alloc_gnt    = alloc_req & ~full;
  assign alloc_tag    = alloc_ptr;
  assign in_use_count = count;
  assign err_pulse    = err_q;

  always_comb begin
    packet_status = 2'b00;
    for (int i = 0; i < N; i++) begin
      if (reorder_tag_out == TAG_WIDTH'(i)) begin
        case (slot_q[i])
          S_REJECTED: packet_status = 2'b01;
          S_ACCEPTED: packet_status = 2'b11;
          default:    packet_status = 2'b00;
        endcase
      end
    end
  end

  // Out-of-range tags look like FREE slots, which makes them protocol errors.
  always_comb begin
    verd_slot = S_FREE;
    rel_slot  = S_FREE;
    for (int i = 0; i < N; i++) begin
      if (verdict_tag == TAG_WIDTH'(i)) verd_slot = slot_q[i];
      if (rel_ptr == TAG_WIDTH'(i))     rel_slot  = slot_q[i];
    end
    verd_err = verdict_valid & (verd_slot == S_FREE);
    rel_ok   = release_valid & (release_tag == rel_ptr) &
               ((rel_slot == S_REJECTED) | (rel_slot == S_ACCEPTED));
    rel_err  = release_valid & ~rel_ok;
  end

`ifdef REORDER_TIMEOUT_EN
  localparam int AW = $clog2(TIMEOUT_CYCLES + 1);
  logic [AW-1:0] age_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) age_q[i] <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (alloc_gnt && alloc_ptr == TAG_WIDTH'(i)) age_q[i] <= '0;
        else if (slot_q[i] == S_PENDING)            age_q[i] <= age_q[i] + AW'(1);
      end
    end
  end

  always_comb begin
    timeout_hit = '0;
    for (int i = 0; i < N; i++)
      timeout_hit[i] = (slot_q[i] == S_PENDING) && (age_q[i] == AW'(TIMEOUT_CYCLES - 1));
  end
`else
  assign timeout_hit = '0;
`endif

  // Release beats verdict/timeout on the same slot; a verdict in the same cycle beats the timeout.
  always_comb begin
    timeout_fire = '0;
    for (int i = 0; i < N; i++) begin
      slot_d[i] = slot_q[i];
      timeout_fire[i] = timeout_hit[i] & ~(verdict_valid && verdict_tag == TAG_WIDTH'(i));
      if (timeout_fire[i]) slot_d[i] = S_REJECTED;
      if (verdict_valid && verdict_tag == TAG_WIDTH'(i) && slot_q[i] == S_PENDING)
        slot_d[i] = verdict_accept ? S_ACCEPTED : S_REJECTED;
      if (alloc_gnt && alloc_ptr == TAG_WIDTH'(i)) slot_d[i] = S_PENDING;
      if (rel_ok && rel_ptr == TAG_WIDTH'(i))      slot_d[i] = S_FREE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) slot_q[i] <= S_FREE;
      alloc_ptr <= '0;
      rel_ptr   <= '0;
      count     <= '0;
      err_q     <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) slot_q[i] <= slot_d[i];
      if (alloc_gnt) alloc_ptr <= (alloc_ptr == LAST_TAG) ? '0 : alloc_ptr + TAG_WIDTH'(1);
      if (rel_ok)    rel_ptr   <= (rel_ptr == LAST_TAG) ? '0 : rel_ptr + TAG_WIDTH'(1);
      count <= count + TAG_WIDTH'(alloc_gnt) - TAG_WIDTH'(rel_ok);
      err_q <= verd_err | rel_err | (|timeout_fire);
    end
  end

endmodule

// File: tb/tb_reorder_tag_manager.sv
// Self-checking bench for reorder_tag_manager: directed scenarios with literal
// expectations plus randomized traffic checked against a slot-list model.
module tb_reorder_tag_manager;
  localparam int TW = 6;
  localparam int N  = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          alloc_req;
  logic          alloc_gnt;
  logic [TW-1:0] alloc_tag;
  logic          verdict_valid;
  logic [TW-1:0] verdict_tag;
  logic          verdict_accept;
  logic [TW-1:0] reorder_tag_out;
  logic [1:0]    packet_status;
  logic          release_valid;
  logic [TW-1:0] release_tag;
  logic          full;
  logic          empty;
  logic [TW-1:0] in_use_count;
  logic          err_pulse;

  reorder_tag_manager #(.TAG_WIDTH(TW), .CIRCULAR_BUFFER_SIZE(N), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst),
    .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
    .verdict_valid(verdict_valid), .verdict_tag(verdict_tag), .verdict_accept(verdict_accept),
    .reorder_tag_out(reorder_tag_out), .packet_status(packet_status),
    .release_valid(release_valid), .release_tag(release_tag),
    .full(full), .empty(empty), .in_use_count(in_use_count), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: 0 free, 1 pending, 2 rejected, 3 accepted
  int m_st [N];
  int m_aptr;
  int m_rptr;
  bit m_err;

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < N; i++) if (m_st[i] != 0) c++;
    return c;
  endfunction

  function automatic int m_status(int tag);
    if (tag >= N) return 0;
    if (m_st[tag] == 2) return 1;
    if (m_st[tag] == 3) return 3;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_st[i] = 0;
    m_aptr = 0;
    m_rptr = 0;
    m_err  = 0;
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    int g;
    g = (alloc_req && m_count() < N) ? 1 : 0;
    chk("alloc_gnt", int'(alloc_gnt), g);
    if (g == 1) chk("alloc_tag", int'(alloc_tag), m_aptr);
    chk("packet_status", int'(packet_status), m_status(int'(reorder_tag_out)));
    chk("full", int'(full), (m_count() == N) ? 1 : 0);
    chk("empty", int'(empty), (m_count() == 0) ? 1 : 0);
    chk("in_use_count", int'(in_use_count), m_count());
    chk("err_pulse", int'(err_pulse), int'(m_err));
  endtask

  task automatic drive(bit areq, bit vv, int vtag, bit vacc, int rto, bit rv, int rtag);
    @(negedge clk);
    alloc_req       = areq;
    verdict_valid   = vv;
    verdict_tag     = TW'(vtag);
    verdict_accept  = vacc;
    reorder_tag_out = TW'(rto);
    release_valid   = rv;
    release_tag     = TW'(rtag);
    #1;
    compare_model();
  endtask

  // Applies the rules to the inputs present at this rising edge.
  task automatic tick();
    int  nst [N];
    bit  gnt, verr, rok, rerr;
    int  vt, rt;
    @(posedge clk);
    for (int i = 0; i < N; i++) nst[i] = m_st[i];
    gnt  = alloc_req && (m_count() < N);
    vt   = int'(verdict_tag);
    rt   = int'(release_tag);
    verr = 0;
    if (verdict_valid) begin
      if (vt >= N || m_st[vt] == 0) verr = 1;
      else if (m_st[vt] == 1) nst[vt] = verdict_accept ? 3 : 2;
    end
    rok  = release_valid && (rt == m_rptr) && (m_st[m_rptr] >= 2);
    rerr = release_valid && !rok;
    if (gnt) begin
      nst[m_aptr] = 1;
      m_aptr = (m_aptr + 1) % N;
    end
    if (rok) begin
      nst[m_rptr] = 0;
      m_rptr = (m_rptr + 1) % N;
    end
    for (int i = 0; i < N; i++) m_st[i] = nst[i];
    m_err = verr || rerr;
  endtask

  task automatic check_reset_values(string tagname);
    chk({tagname, "_count"}, int'(in_use_count), 0);
    chk({tagname, "_empty"}, int'(empty), 1);
    chk({tagname, "_full"}, int'(full), 0);
    chk({tagname, "_alloc_tag"}, int'(alloc_tag), 0);
    chk({tagname, "_status"}, int'(packet_status), 0);
    chk({tagname, "_err"}, int'(err_pulse), 0);
  endtask

  initial begin
    rst = 1'b1;
    alloc_req = 1'b1; verdict_valid = 1'b0; verdict_tag = '0; verdict_accept = 1'b0;
    reorder_tag_out = '0; release_valid = 1'b0; release_tag = '0;
    model_reset();
    #2;
    check_reset_values("rst");
    chk("rst_gnt_follows_req", int'(alloc_gnt), 1);
    alloc_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Fill: three grants, fourth blocked
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 0, 0, 0, 0);
      chk("fill_gnt", int'(alloc_gnt), (k < 3) ? 1 : 0);
      if (k < 3) chk("fill_tag", int'(alloc_tag), k);
      else begin
        chk("fill_full", int'(full), 1);
        chk("fill_count", int'(in_use_count), 3);
      end
      tick();
    end

    // Verdicts: tag1 accept, tag0 reject
    drive(0, 1, 1, 1, 0, 0, 0); tick();
    drive(0, 1, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("status_tag0", int'(packet_status), 1);
    reorder_tag_out = TW'(1); #1;
    chk("status_tag1", int'(packet_status), 3);
    reorder_tag_out = TW'(2); #1;
    chk("status_tag2", int'(packet_status), 0);
    tick();

    // Second verdict on an accepted slot is ignored silently
    drive(0, 1, 1, 0, 1, 0, 0); tick();
    drive(0, 0, 0, 0, 1, 0, 0);
    chk("reverdict_status", int'(packet_status), 3);
    chk("reverdict_err", int'(err_pulse), 0);
    tick();

    // Out-of-order release is an error and changes nothing
    drive(0, 0, 0, 0, 0, 1, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ooo_rel_err", int'(err_pulse), 1);
    chk("ooo_rel_count", int'(in_use_count), 3);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("ooo_rel_err_clear", int'(err_pulse), 0);
    tick();

    // Release while full with a simultaneous request
    drive(1, 0, 0, 0, 0, 1, 0);
    chk("full_rel_gnt", int'(alloc_gnt), 0);
    tick();
    drive(1, 0, 0, 0, 0, 0, 0);
    chk("after_rel_count", int'(in_use_count), 2);
    chk("after_rel_gnt", int'(alloc_gnt), 1);
    chk("after_rel_tag", int'(alloc_tag), 0);
    tick();

    // Randomized traffic with one asynchronous reset mid-run
    for (int c = 0; c < 3000; c++) begin
      bit areq, vv, vacc, rv;
      int vtag, rtag, rto;
      if (c == 1500) begin
        @(negedge clk);
        alloc_req = 1'b0; verdict_valid = 1'b0; release_valid = 1'b0;
        reorder_tag_out = '0;
        #2 rst = 1'b1;
        #1;
        check_reset_values("midrst");
        model_reset();
        @(negedge clk);
        rst = 1'b0;
      end
      areq = ($urandom_range(0, 99) < 60);
      vv   = ($urandom_range(0, 99) < 50);
      vtag = ($urandom_range(0, 99) < 90) ? int'($urandom_range(0, N - 1)) : int'($urandom_range(N, 63));
      vacc = 1'($urandom_range(0, 1));
      rv   = ($urandom_range(0, 99) < 40);
      rtag = ($urandom_range(0, 99) < 80) ? m_rptr : int'($urandom_range(0, N));
      rto  = int'($urandom_range(0, N));
      drive(areq, vv, vtag, vacc, rto, rv, rtag);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
